// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel tick / square-wave divider.
package clkdiv_pkg;
  localparam int CNT_W_DEF   = 24;
  localparam int DEF_DIV_DEF = 12000000;
  localparam int MIN_DIV     = 2;

  // Channel-select width; a single channel still needs a one-bit select.
  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/clkdiv_multi_if.sv
// Control and output bundle of the divider block: run enables, sync, divisor write bus,
// and per-channel pend/tick/sq outputs.
interface clkdiv_multi_if
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEF
) ();
  localparam int CH_W = ch_width(NUM_CH);

  logic [NUM_CH-1:0] en;
  logic              sync;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [CNT_W-1:0]  wr_div;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;

  modport master (output en, sync, wr_en, wr_ch, wr_div, input pend, tick, sq);
  modport slave  (input en, sync, wr_en, wr_ch, wr_div, output pend, tick, sq);
endinterface

// File: rtl/clkdiv_channel.sv
// One divider channel: shadowed period, free-running counter, registered tick and square wave.
// Outputs lag the counter by one cycle; writes are always accepted, applied at wrap, disable or sync.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             pend,
  output logic             tick,
  output logic             sq
);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] active;
  logic [CNT_W-1:0] shadow;
  logic [CNT_W-1:0] lim;
  logic [CNT_W-1:0] last;
  logic [CNT_W-1:0] sq_thr;
  logic             wrap;
  logic             apply;

  // Periods below two are kept as written but run as two so tick and sq stay well formed.
  assign lim    = (active < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : active;
  assign last   = lim - CNT_W'(1);
  assign sq_thr = lim - (lim >> 1);
  assign wrap   = (cnt == last);
  assign apply  = wrap || !en || sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      active <= CNT_W'(DEF_DIV);
      shadow <= CNT_W'(DEF_DIV);
      pend   <= 1'b0;
      tick   <= 1'b0;
      sq     <= 1'b0;
    end else begin
      if (sync || !en) begin
        cnt  <= '0;
        tick <= 1'b0;
        sq   <= 1'b0;
      end else begin
        cnt  <= wrap ? '0 : cnt + CNT_W'(1);
        tick <= wrap;
        sq   <= (cnt >= sq_thr);
      end

      if (apply) begin
        active <= shadow;
      end

      // A write landing on an apply point waits for the next one.
      if (wr) begin
        shadow <= wr_div;
        pend   <= 1'b1;
      end else if (apply) begin
        pend   <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/clkdiv_multi.sv
// NUM_CH independent programmable tick/square-wave dividers sharing sync, reset and a write bus.
// One-cycle output latency; out-of-range channel writes are dropped, no backpressure.
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic           BOARD_CLK,
  input  logic           BOARD_RST,
  clkdiv_multi_if.slave  bus
);
  localparam int CH_W = ch_width(NUM_CH);

  logic [NUM_CH-1:0] pend_v;
  logic [NUM_CH-1:0] tick_v;
  logic [NUM_CH-1:0] sq_v;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_sel;

    // wr_ch values at or above NUM_CH match no channel and are ignored.
    assign wr_sel = bus.wr_en && (bus.wr_ch == CH_W'(i));

    clkdiv_channel #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk    (BOARD_CLK),
      .rst    (BOARD_RST),
      .en     (bus.en[i]),
      .sync   (bus.sync),
      .wr     (wr_sel),
      .wr_div (bus.wr_div),
      .pend   (pend_v[i]),
      .tick   (tick_v[i]),
      .sq     (sq_v[i])
    );
  end

  assign bus.pend = pend_v;
  assign bus.tick = tick_v;
  assign bus.sq   = sq_v;
endmodule

// File: tb/tb_clkdiv_multi.sv
// Scoreboard bench for clkdiv_multi: stimulus queues expected {pend,tick,sq} per cycle,
// a negedge monitor pops and compares.
module tb_clkdiv_multi;
  import clkdiv_pkg::*;

  localparam int NCH = 5;
  localparam int CW  = 24;
  localparam int VW  = 3 * NCH;
  localparam int CHW = ch_width(NCH);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clkdiv_multi_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

  clkdiv_multi #(.NUM_CH(NCH), .CNT_W(CW), .DEF_DIV(4)) dut (
    .BOARD_CLK (clk),
    .BOARD_RST (rst),
    .bus       (bus)
  );

  typedef struct {
    string            name;
    logic [VW-1:0]    exp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   kk[NCH];
  int   pp[NCH];

  // {tick, sq} k edges after a counter restart at period p; k <= 0 means held low.
  function automatic logic [1:0] wave(input int k, input int p);
    int r;
    if (k <= 0) return 2'b00;
    r = k % p;
    return {(r == 0), (r == 0) || (r > p - p / 2)};
  endfunction

  task automatic push_exp(input string name, input logic [NCH-1:0] pend);
    exp_t            e;
    logic [NCH-1:0]  t;
    logic [NCH-1:0]  s;
    logic [1:0]      w;
    for (int c = 0; c < NCH; c++) begin
      w    = wave(kk[c], pp[c]);
      t[c] = w[1];
      s[c] = w[0];
    end
    e.name = name;
    e.exp  = {pend, t, s};
    sb.push_back(e);
  endtask

  task automatic set_all(input int n);
    for (int c = 0; c < NCH; c++) begin
      kk[c] = n;
      pp[c] = 4;
    end
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int ch, input int div);
    bus.wr_en  = 1'b1;
    bus.wr_ch  = CHW'(ch);
    bus.wr_div = CW'(div);
  endtask

  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    #1;
    rst       = 1'b1;
    bus.en    = '1;
    bus.sync  = 1'b0;
    bus.wr_en = 1'b0;
    e.name    = "reset";
    e.exp     = '0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    exp_t          e;
    logic [VW-1:0] got;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {bus.pend, bus.tick, bus.sq};
        checks++;
        if (got !== e.exp) begin
          failures++;
          $display("FAIL %s: got pend=%b tick=%b sq=%b, expected pend=%b tick=%b sq=%b",
                   e.name, bus.pend, bus.tick, bus.sq,
                   e.exp[3*NCH-1 -: NCH], e.exp[2*NCH-1 -: NCH], e.exp[NCH-1:0]);
        end
      end
    end
  end

  initial begin
    logic [NCH-1:0] pe;
    bus.en     = '1;
    bus.sync   = 1'b0;
    bus.wr_en  = 1'b0;
    bus.wr_ch  = '0;
    bus.wr_div = '0;

    do_reset();
    for (int n = 1; n <= 8; n++) begin
      edge_wait();
      set_all(n);
      push_exp($sformatf("default n=%0d", n), '0);
    end

    // ch1 -> 6 mid-period: old period finishes, then 6.
    do_reset();
    for (int n = 1; n <= 16; n++) begin
      if (n == 2) write(1, 6); else bus.wr_en = 1'b0;
      edge_wait();
      set_all(n);
      if (n > 4) begin kk[1] = n - 4; pp[1] = 6; end
      pe = '0;
      pe[1] = (n == 2 || n == 3);
      push_exp($sformatf("wr6 n=%0d", n), pe);
    end

    // ch0 -> 1 then 0: both run as period 2.
    do_reset();
    for (int n = 1; n <= 12; n++) begin
      if (n == 1) write(0, 1);
      else if (n == 7) write(0, 0);
      else bus.wr_en = 1'b0;
      edge_wait();
      set_all(n);
      if (n > 4) begin kk[0] = n - 4; pp[0] = 2; end
      pe = '0;
      pe[0] = (n <= 3 || n == 7);
      push_exp($sformatf("min_div n=%0d", n), pe);
    end

    // ch2 -> 5 on its wrap cycle: deferred to the following wrap.
    do_reset();
    for (int n = 1; n <= 18; n++) begin
      if (n == 4) write(2, 5); else bus.wr_en = 1'b0;
      edge_wait();
      set_all(n);
      if (n > 8) begin kk[2] = n - 8; pp[2] = 5; end
      pe = '0;
      pe[2] = (n >= 4 && n <= 7);
      push_exp($sformatf("wr_at_wrap n=%0d", n), pe);
    end

    // ch3 disabled for 10 cycles with a write to 3 while low.
    do_reset();
    for (int n = 1; n <= 18; n++) begin
      bus.en[3] = !(n >= 3 && n <= 12);
      if (n == 5) write(3, 3); else bus.wr_en = 1'b0;
      edge_wait();
      set_all(n);
      if (n >= 3 && n <= 12) kk[3] = 0;
      else if (n >= 13) begin kk[3] = n - 12; pp[3] = 3; end
      pe = '0;
      pe[3] = (n == 5);
      push_exp($sformatf("en_low n=%0d", n), pe);
    end

    // Mixed periods, sync realignment, out-of-range write, then async reset pulse.
    do_reset();
    for (int n = 1; n <= 25; n++) begin
      bus.sync = (n == 12);
      case (n)
        1:       write(1, 6);
        2:       write(2, 5);
        10:      write(0, 3);
        11:      write(5, 2);
        25:      write(2, 7);
        default: bus.wr_en = 1'b0;
      endcase
      edge_wait();
      if (n < 12) begin
        set_all(n);
        if (n > 4) begin
          kk[1] = n - 4; pp[1] = 6;
          kk[2] = n - 4; pp[2] = 5;
        end
      end else if (n == 12) begin
        set_all(0);
      end else begin
        set_all(n - 12);
        pp[0] = 3; pp[1] = 6; pp[2] = 5;
      end
      pe = '0;
      pe[0] = (n == 10 || n == 11);
      pe[1] = (n <= 3);
      pe[2] = (n == 2 || n == 3 || n == 25);
      push_exp($sformatf("sync n=%0d", n), pe);
    end

    @(negedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.sync  = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      edge_wait();
      set_all(n);
      push_exp($sformatf("after_async_rst n=%0d", n), '0);
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
